// File: rtl/rot_seq_5b.sv
// rot_seq_5b: multi-cycle rotate unit (ROL/ROR/RCL/RCR) for 8/16/32-bit operands.
// The working vector is held in a 33-bit register. The active ring is W bits for
// plain rotates and W+1 bits ({CF, A}) for rotate-through-carry. The unit advances
// the ring by at most four positions per cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE. out_valid is high only in DONE and stays
// high, with stable data, until out_ready is seen. Inputs presented outside IDLE
// are ignored.
module rot_seq_5b (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [4:0]  cnt,
   input  logic [1:0]  op,
   input  logic [1:0]  opSize,
   input  logic        cf_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        cf_out,
   output logic        of_out,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state, state_n;

   // Operands latched when a request is accepted.
   logic [1:0]  op_r;
   logic [1:0]  sz_r;
   logic        cf_r;
   logic        cnt0_r;
   logic        cnt1_r;
   logic [31:0] data_r;
   logic [4:0]  rem_r;
   logic [32:0] vec_r;

   // Size decoding. Size code 11 is folded into dword.
   logic [1:0]  sz_in;
   logic [4:0]  e_in;

   // Values currently in use: the live inputs while idle, the latched copies otherwise.
   logic [1:0]  op_c;
   logic [1:0]  sz_c;
   logic        cf_c;
   logic        cnt0_c;
   logic        cnt1_c;
   logic [31:0] data_c;
   logic [5:0]  w_c;
   logic [5:0]  n_c;
   logic [31:0] wmask_c;
   logic [31:0] msb_c;
   logic [32:0] vec_init;
   logic [32:0] src_c;
   logic [2:0]  step_c;
   logic [32:0] fin_c;

   logic [31:0] res_c;
   logic        carry_c;
   logic        cf_next;
   logic        of_next;
   logic        accept;
   logic        enter_done;

   // One-position rotate of an n-bit ring that sits in the low bits of v.
   function automatic logic [32:0] rot1(input logic [32:0] v, input logic [5:0] n,
                                        input logic right);
      logic [32:0] m;
      logic [32:0] top;
      logic        b;
      m   = (33'h1 << n) - 33'h1;
      top = 33'h1 << (n - 6'd1);
      if (right) begin
         b = v[0];
         return ((v >> 1) | (b ? top : 33'h0)) & m;
      end else begin
         b = |(v & top);
         return ((v << 1) & m) | {32'h0, b};
      end
   endfunction

   assign accept     = (state == S_IDLE) && in_valid;
   assign enter_done = (state_n == S_DONE) && (state != S_DONE);

   // Effective count of the incoming request: mod W for plain rotates, mod W+1 through carry.
   always_comb begin
      sz_in = (opSize == 2'b11) ? 2'b10 : opSize;
      e_in  = cnt;
      if (!op[1]) begin
         case (sz_in)
            2'b00:   e_in = {2'b00, cnt[2:0]};
            2'b01:   e_in = {1'b0, cnt[3:0]};
            default: e_in = cnt;
         endcase
      end else begin
         case (sz_in)
            2'b00: begin
               if      (cnt >= 5'd27) e_in = cnt - 5'd27;
               else if (cnt >= 5'd18) e_in = cnt - 5'd18;
               else if (cnt >= 5'd9)  e_in = cnt - 5'd9;
               else                   e_in = cnt;
            end
            2'b01:   e_in = (cnt >= 5'd17) ? cnt - 5'd17 : cnt;
            default: e_in = cnt;
         endcase
      end
   end

   // Operand selection, ring width and masks for the operation in flight.
   always_comb begin
      op_c   = (state == S_IDLE) ? op      : op_r;
      sz_c   = (state == S_IDLE) ? sz_in   : sz_r;
      cf_c   = (state == S_IDLE) ? cf_in   : cf_r;
      cnt0_c = (state == S_IDLE) ? (cnt == 5'd0) : cnt0_r;
      cnt1_c = (state == S_IDLE) ? (cnt == 5'd1) : cnt1_r;
      data_c = (state == S_IDLE) ? in_data : data_r;
      case (sz_c)
         2'b00:   begin w_c = 6'd8;  wmask_c = 32'h0000_00FF; end
         2'b01:   begin w_c = 6'd16; wmask_c = 32'h0000_FFFF; end
         default: begin w_c = 6'd32; wmask_c = 32'hFFFF_FFFF; end
      endcase
      msb_c    = 32'h1 << (w_c - 6'd1);
      n_c      = op_c[1] ? w_c + 6'd1 : w_c;
      vec_init = {1'b0, in_data & wmask_c};
      if (op_c[1]) vec_init = vec_init | (33'h1 << w_c & {32'h0, 1'b0} | ({32'h0, cf_in} << w_c));
   end

   // Ring advance for this cycle: zero positions while idle, min(remaining, 4) while busy.
   always_comb begin
      src_c  = (state == S_IDLE) ? vec_init : vec_r;
      step_c = 3'd0;
      if (state == S_BUSY) step_c = (rem_r > 5'd4) ? 3'd4 : rem_r[2:0];
      fin_c = src_c;
      for (int i = 0; i < 4; i++) begin
         if (step_c > i[2:0]) fin_c = rot1(fin_c, n_c, op_c[0]);
      end
   end

   // Result and flag formation from the ring contents.
   always_comb begin
      res_c   = (data_c & ~wmask_c) | (fin_c[31:0] & wmask_c);
      carry_c = |(fin_c & (33'h1 << w_c));
      if (cnt0_c)        cf_next = cf_c;
      else if (op_c[1])  cf_next = carry_c;
      else if (op_c[0])  cf_next = |(res_c & msb_c);
      else               cf_next = res_c[0];
      of_next = 1'b0;
      if (cnt1_c) begin
         if (op_c[0]) of_next = (|(res_c & msb_c)) ^ (|(res_c & (msb_c >> 1)));
         else         of_next = (|(res_c & msb_c)) ^ cf_next;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (in_valid) state_n = (e_in == 5'd0) ? S_DONE : S_BUSY;
         S_BUSY:  if (rem_r <= 5'd4) state_n = S_DONE;
         S_DONE:  if (out_ready) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Handshake outputs and state visibility.
   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
      dbg_state = state;
   end

   // Operand capture at acceptance and ring/counter update while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r   <= 2'b00;
         sz_r   <= 2'b00;
         cf_r   <= 1'b0;
         cnt0_r <= 1'b0;
         cnt1_r <= 1'b0;
         data_r <= 32'h0;
         rem_r  <= 5'd0;
         vec_r  <= 33'h0;
      end else if (accept) begin
         op_r   <= op;
         sz_r   <= sz_in;
         cf_r   <= cf_in;
         cnt0_r <= (cnt == 5'd0);
         cnt1_r <= (cnt == 5'd1);
         data_r <= in_data;
         rem_r  <= e_in;
         vec_r  <= fin_c;
      end else if (state == S_BUSY) begin
         rem_r  <= rem_r - {2'b00, step_c};
         vec_r  <= fin_c;
      end
   end

   // Registered result, loaded only on the transition into DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= 32'h0;
         cf_out   <= 1'b0;
         of_out   <= 1'b0;
      end else if (enter_done) begin
         out_data <= res_c;
         cf_out   <= cf_next;
         of_out   <= of_next;
      end
   end

endmodule

// File: tb/tb_rot_seq_5b.sv
// tb_rot_seq_5b: directed and random checks of rot_seq_5b against a wide-arithmetic reference.
module tb_rot_seq_5b;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  cnt;
   logic [1:0]  op;
   logic [1:0]  opSize;
   logic        cf_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        cf_out;
   logic        of_out;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   rot_seq_5b dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .cnt       (cnt),
      .op        (op),
      .opSize    (opSize),
      .cf_in     (cf_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cf_out    (cf_out),
      .of_out    (of_out),
      .dbg_state (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: rotate the W or W+1 bit ring as one wide integer.
   function automatic void model(input logic [31:0] d, input logic [4:0] c, input logic [1:0] o,
                                 input logic [1:0] sz, input logic cf,
                                 output logic [31:0] r, output logic cfo, output logic ofo,
                                 output int lat);
      int w, n, e, l;
      logic [63:0] v, m, rv;
      logic [31:0] wm;
      w  = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
      n  = o[1] ? w + 1 : w;
      e  = int'(c) % n;
      wm = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      v  = {32'h0, d & wm};
      if (o[1]) v = v | ({63'h0, cf} << w);
      l  = o[0] ? (n - e) % n : e;
      m  = (64'h1 << n) - 64'h1;
      rv = ((v << l) | (v >> (n - l))) & m;
      r  = (d & ~wm) | (rv[31:0] & wm);
      if (c == 5'd0)  cfo = cf;
      else if (o[1])  cfo = rv[w];
      else if (o[0])  cfo = rv[w-1];
      else            cfo = rv[0];
      ofo = 1'b0;
      if (c == 5'd1) ofo = o[0] ? (rv[w-1] ^ rv[w-2]) : (rv[w-1] ^ cfo);
      lat = 1 + (e + 3) / 4;
   endfunction

   // Driver: present one request, wait for the result, hold it for 'hold' cycles, then accept.
   task automatic run_op(input logic [31:0] d, input logic [4:0] c, input logic [1:0] o,
                         input logic [1:0] sz, input logic cf, input int hold);
      logic [31:0] er;
      logic        ecf, eof;
      int          elat, lat;
      model(d, c, o, sz, cf, er, ecf, eof, elat);
      @(negedge clk);
      check("in_ready_idle", {31'h0, in_ready}, 32'h1);
      in_valid = 1'b1; in_data = d; cnt = c; op = o; opSize = sz; cf_in = cf; out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_data = $urandom; cnt = 5'($urandom); op = 2'($urandom);
      opSize = 2'($urandom); cf_in = 1'($urandom);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
         check("in_ready_busy", {31'h0, in_ready}, 32'h0);
         in_valid = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      check("latency", lat, elat);
      check("out_data", out_data, er);
      check("cf_out", {31'h0, cf_out}, {31'h0, ecf});
      check("of_out", {31'h0, of_out}, {31'h0, eof});
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         in_data  = $urandom;
         cnt      = 5'($urandom);
         @(negedge clk);
         check("hold_valid", {31'h0, out_valid}, 32'h1);
         check("hold_in_ready", {31'h0, in_ready}, 32'h0);
         check("hold_data", out_data, er);
         check("hold_flags", {30'h0, cf_out, of_out}, {30'h0, ecf, eof});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("post_out_valid", {31'h0, out_valid}, 32'h0);
      check("post_in_ready", {31'h0, in_ready}, 32'h1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; cnt = 5'd0; op = 2'd0;
      opSize = 2'd0; cf_in = 1'b0; out_ready = 1'b0;
      #12;
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_flags", {30'h0, cf_out, of_out}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {31'h0, in_ready}, 32'h1);

      // Directed cases
      run_op(32'h8000_0001, 5'd1,  2'b00, 2'b10, 1'b0, 0);
      run_op(32'hAAAA_AA01, 5'd1,  2'b11, 2'b00, 1'b0, 0);
      run_op(32'h1234_5678, 5'd17, 2'b10, 2'b01, 1'b1, 0);
      run_op(32'h0000_0001, 5'd31, 2'b01, 2'b10, 1'b0, 0);
      run_op(32'h0000_00F1, 5'd8,  2'b00, 2'b00, 1'b0, 0);
      run_op(32'hDEAD_BEEF, 5'd0,  2'b01, 2'b11, 1'b1, 0);
      run_op(32'h5555_8001, 5'd1,  2'b01, 2'b01, 1'b0, 0);
      run_op(32'hCAFE_0081, 5'd9,  2'b10, 2'b00, 1'b1, 0);
      run_op(32'h0F0F_F0F0, 5'd31, 2'b11, 2'b11, 1'b1, 0);

      // Backpressure: result held while in_valid toggles
      run_op(32'h1357_9BDF, 5'd13, 2'b10, 2'b10, 1'b1, 5);

      // Reset mid-BUSY after an operation that left nonzero outputs
      run_op(32'h0000_00F1, 5'd8, 2'b00, 2'b00, 1'b0, 0);
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h0000_0001; cnt = 5'd31; op = 2'b01; opSize = 2'b10; cf_in = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
      check("midrst_out_data", out_data, 32'h0);
      check("midrst_flags", {30'h0, cf_out, of_out}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
      check("midrst_out_valid2", {31'h0, out_valid}, 32'h0);
      run_op(32'h0000_0001, 5'd4, 2'b00, 2'b10, 1'b0, 0);

      // Random operations with random result backpressure
      for (int i = 0; i < 80; i++) begin
         run_op($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
